// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one combinational-read instruction ROM between the
// CPU fetch port and an APB read-only slave. Fetch has priority; a starvation
// counter guarantees that a pending APB read is served after at most
// APB_MAX_WAIT lost cycles. Both response paths are registered.
module rom_access_arbiter #(
  parameter int unsigned ROM_DEPTH    = 4096,
  parameter int unsigned APB_AW       = 14,
  parameter int unsigned APB_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // APB slave port
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  // ROM port
  output logic [31:0]       rom_addr,
  input  logic [31:0]       rom_data
);

  localparam int unsigned CNT_W   = (APB_MAX_WAIT < 2) ? 1 : $clog2(APB_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(APB_MAX_WAIT);
  // 33 bits so ROM_DEPTH*4 never wraps against a full 32-bit address
  localparam logic [32:0] ROM_BYTES = 33'(ROM_DEPTH) << 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_ERR  = 2'd2
  } apb_state_e;

  apb_state_e       state_q;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             if_rvalid_q;
  logic [31:0]      if_rdata_q;
  logic [31:0]      prdata_q;
  logic             pready_q;
  logic             pslverr_q;

  logic [31:0]      paddr_ext;
  logic             apb_access;
  logic             apb_in_range;
  logic             apb_pend;
  logic             apb_win;
  logic             pwdata_unused;

  // Write data is never consumed: writes are answered with an error.
  assign pwdata_unused = ^PWDATA;

  assign paddr_ext    = 32'(PADDR);
  // Only an access phase seen in IDLE counts, so a held PSEL/PENABLE during
  // the response cycle cannot trigger a second read.
  assign apb_access   = (state_q == ST_IDLE) && PSEL && PENABLE;
  assign apb_in_range = ({1'b0, paddr_ext} < ROM_BYTES);
  assign apb_pend     = apb_access && !PWRITE && apb_in_range;
  assign apb_win      = apb_pend && (!if_req || (starve_q == MAX_CNT));
  assign if_gnt       = if_req && !apb_win;
  assign rom_addr     = apb_win ? paddr_ext : if_addr;

  // Starvation counter next state: counts cycles a pending APB read loses to fetch.
  always_comb begin
    starve_d = starve_q;
    if (!apb_pend || apb_win) begin
      starve_d = '0;
    end else if (if_gnt && (starve_q != MAX_CNT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Fetch response: capture ROM word one cycle after each grant, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= if_gnt;
      if (if_gnt) begin
        if_rdata_q <= rom_data;
      end
    end
  end

  // APB response FSM with registered PREADY/PSLVERR/PRDATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (apb_win) begin
            state_q   <= ST_RESP;
            prdata_q  <= rom_data;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
          end else if (apb_access && (PWRITE || !apb_in_range)) begin
            state_q   <= ST_ERR;
            prdata_q  <= '0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Randomized self-checking bench for rom_access_arbiter with a cycle-level
// reference model plus transfer-level APB checks.
module tb_rom_access_arbiter;

  localparam int DEPTH = 4096;
  localparam int AW    = 15;   // one spare bit so out-of-range addresses are reachable
  localparam int MAXW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [31:0]   rom_addr;
  logic [31:0]   rom_data;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic        exp_rvalid, exp_pready, exp_pslverr;
  logic [31:0] exp_rdata, exp_prdata;
  int          m_wait;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return ({20'h0, a[13:2]} * 32'h9E3779B1) ^ 32'hC3A5_1E7D;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  rom_access_arbiter #(
    .ROM_DEPTH(DEPTH), .APB_AW(AW), .APB_MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check arbitration outputs, advance model, check registered outputs.
  task automatic step();
    logic acc, is_err, pend, win;
    logic [31:0] pa;
    #1;
    pa     = {17'b0, paddr};
    acc    = psel && penable && !exp_pready;
    is_err = pwrite || (pa >= 32'(DEPTH * 4));
    pend   = acc && !is_err;
    win    = pend && (!if_req || (m_wait == MAXW));
    check_eq("if_gnt", {31'b0, if_gnt}, {31'b0, if_req && !win});
    check_eq("rom_addr", rom_addr, win ? pa : if_addr);
    @(posedge clk);
    if (reset) begin
      exp_rvalid = 1'b0; exp_rdata = '0;
      exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0;
      m_wait = 0;
    end else begin
      exp_rvalid = if_req && !win;
      if (exp_rvalid) exp_rdata = rom_fn(if_addr);
      if (win) begin
        exp_pready = 1'b1; exp_pslverr = 1'b0; exp_prdata = rom_fn(pa);
      end else if (acc && is_err) begin
        exp_pready = 1'b1; exp_pslverr = 1'b1; exp_prdata = '0;
      end else begin
        exp_pready = 1'b0; exp_pslverr = 1'b0;
      end
      m_wait = (pend && !win) ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;
    end
    #1;
    check_eq("if_rvalid", {31'b0, if_rvalid}, {31'b0, exp_rvalid});
    check_eq("if_rdata", if_rdata, exp_rdata);
    check_eq("PREADY", {31'b0, pready}, {31'b0, exp_pready});
    check_eq("PSLVERR", {31'b0, pslverr}, {31'b0, exp_pslverr});
    check_eq("PRDATA", prdata, exp_prdata);
  endtask

  initial begin
    int            ap_state;
    int            ap_cycles;
    int            req_pct;
    logic [AW-1:0] ap_addr;
    logic          ap_write, ap_err;

    exp_rvalid = 0; exp_rdata = '0; exp_pready = 0; exp_pslverr = 0; exp_prdata = '0;
    m_wait = 0;
    pwdata = 32'hDEAD_BEEF;
    psel = 0; penable = 0; pwrite = 0; paddr = '0;

    // reset held 2 cycles with a fetch request pending
    reset = 1; if_req = 1; if_addr = 32'h8;
    step(); step();
    reset = 0;
    step();
    check_eq("t1_rdata", if_rdata, rom_fn(32'h8));
    if_req = 0;
    step();

    // reset sampled on the grant edge drops the response; re-issued read completes
    psel = 1; penable = 0; pwrite = 0; paddr = 15'h10;
    step();
    penable = 1; reset = 1;
    step();
    check_eq("t6_pready_dropped", {31'b0, pready}, 32'd0);
    reset = 0; psel = 0; penable = 0;
    step();
    psel = 1;
    step();
    penable = 1;
    step();
    step();
    check_eq("t6_prdata", prdata, rom_fn(32'h10));
    $display("APB RD addr=%h data=%h err=%0d (reissued after reset)", 15'h10, prdata, pslverr);
    psel = 0; penable = 0;
    step();

    // randomized traffic
    ap_state = 0; ap_cycles = 0; req_pct = 50;
    ap_addr = '0; ap_write = 0; ap_err = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: req_pct = 0;
          1: req_pct = 50;
          2: req_pct = 90;
          default: req_pct = 100;
        endcase
      end
      if (reset) begin
        reset = 0; ap_state = 0; psel = 0; penable = 0;
      end else begin
        case (ap_state)
          0: if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 7))
              0: ap_addr = 15'h3FFC;
              1: ap_addr = 15'h4000;
              2: ap_addr = 15'h0000;
              3: ap_addr = 15'($urandom_range(16384, 32767));
              default: ap_addr = 15'($urandom_range(0, 16383));
            endcase
            ap_write = ($urandom_range(0, 9) == 0);
            ap_err   = ap_write || (ap_addr >= 15'h4000);
            paddr = ap_addr; pwrite = ap_write; psel = 1; penable = 0;
            ap_state = 1;
          end
          1: begin
            penable = 1; ap_cycles = 1; ap_state = 2;
          end
          2: begin
            ap_cycles++;
            if (pready) begin
              check_eq("apb_latency_ok", {31'b0, ap_cycles <= MAXW + 2}, 32'd1);
              check_eq("apb_pslverr", {31'b0, pslverr}, {31'b0, ap_err});
              check_eq("apb_prdata", prdata, ap_err ? 32'h0 : rom_fn({17'b0, ap_addr}));
              $display("APB %s addr=%h data=%h err=%0d access_cycles=%0d",
                       ap_write ? "WR" : "RD", ap_addr, prdata, pslverr, ap_cycles);
              ap_state = 3;
            end else if (ap_cycles > MAXW + 2) begin
              check_eq("apb_timeout", {31'b0, pready}, 32'd1);
              psel = 0; penable = 0; ap_state = 0;
            end
          end
          default: begin
            psel = 0; penable = 0; ap_state = 0;
          end
        endcase
      end
      if_req  = ($urandom_range(0, 99) < req_pct);
      if_addr = $urandom;
      if ($urandom_range(0, 399) == 0) reset = 1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
